// File: rtl/eer_pkg.sv
// Shared definitions for the transmit path: word width, packet type codes,
// per-type frame lengths and the captured-frame struct.
package eer_pkg;

  localparam int unsigned WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    PKT_NONE = 3'd0,
    PKT_HB   = 3'd1,
    PKT_CHE  = 3'd2,
    PKT_INV  = 3'd3,
    PKT_JOIN = 3'd4,
    PKT_DATA = 3'd5
  } pkt_type_e;

  // Total words per frame, header and checksum included
  localparam logic [3:0] LEN_HB   = 4'd6;
  localparam logic [3:0] LEN_CHE  = 4'd5;
  localparam logic [3:0] LEN_INV  = 4'd5;
  localparam logic [3:0] LEN_JOIN = 4'd5;
  localparam logic [3:0] LEN_DATA = 4'd7;

  typedef struct packed {
    pkt_type_e             ptype;
    logic [WORD_WIDTH-1:0] source_id;
    logic [WORD_WIDTH-1:0] destination_id;
    logic [WORD_WIDTH-1:0] source_hops;
    logic [WORD_WIDTH-1:0] q_value;
    logic [WORD_WIDTH-1:0] energy_left;
    logic [WORD_WIDTH-1:0] chosen_ch;
    logic [WORD_WIDTH-1:0] hops_from_ch;
  } tx_frame_t;

  function automatic logic type_is_valid(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd5);
  endfunction

  function automatic logic [3:0] frame_len(input pkt_type_e t);
    case (t)
      PKT_HB:   return LEN_HB;
      PKT_CHE:  return LEN_CHE;
      PKT_INV:  return LEN_INV;
      PKT_JOIN: return LEN_JOIN;
      PKT_DATA: return LEN_DATA;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/pkt_tx_assembler_if.sv
// Valid/ready word link toward the radio/TX FIFO.
//   tx_valid : word on tx_data is valid (master -> slave)
//   tx_data  : current frame word       (master -> slave)
//   tx_last  : current word is checksum (master -> slave)
//   tx_ready : sink accepts this cycle  (slave -> master)
interface pkt_tx_assembler_if #(
  parameter int unsigned WORD_WIDTH = 16
) ();
  logic                  tx_valid;
  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_last;
  logic                  tx_ready;

  modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/pkt_word_sel.sv
// Combinational word selector for one captured frame.
//   i_frame     : captured frame (type + fields)
//   i_idx       : word index, 0 = header
//   o_word      : data word at i_idx (checksum is produced by the caller)
//   o_last_data : i_idx is the last word before the checksum
module pkt_word_sel import eer_pkg::*; (
  input  tx_frame_t             i_frame,
  input  logic [2:0]            i_idx,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_last_data
);
  logic [3:0] w_len;

  always_comb begin
    w_len       = frame_len(i_frame.ptype);
    o_last_data = ({1'b0, i_idx} == (w_len - 4'd2));
    o_word      = '0;
    if (i_idx == 3'd0) begin
      o_word = {i_frame.ptype, 1'b0, w_len, 8'h00};
    end else begin
      case (i_frame.ptype)
        PKT_HB: case (i_idx)
          3'd1: o_word = i_frame.source_id;
          3'd2: o_word = i_frame.source_hops;
          3'd3: o_word = i_frame.q_value;
          3'd4: o_word = i_frame.energy_left;
          default: o_word = '0;
        endcase
        PKT_CHE: case (i_idx)
          3'd1: o_word = i_frame.source_id;
          3'd2: o_word = i_frame.energy_left;
          3'd3: o_word = i_frame.q_value;
          default: o_word = '0;
        endcase
        PKT_INV: case (i_idx)
          3'd1: o_word = i_frame.source_id;
          3'd2: o_word = i_frame.chosen_ch;
          3'd3: o_word = i_frame.hops_from_ch;
          default: o_word = '0;
        endcase
        PKT_JOIN: case (i_idx)
          3'd1: o_word = i_frame.source_id;
          3'd2: o_word = i_frame.destination_id;
          3'd3: o_word = i_frame.chosen_ch;
          default: o_word = '0;
        endcase
        PKT_DATA: case (i_idx)
          3'd1: o_word = i_frame.source_id;
          3'd2: o_word = i_frame.destination_id;
          3'd3: o_word = i_frame.source_hops;
          3'd4: o_word = i_frame.energy_left;
          3'd5: o_word = i_frame.q_value;
          default: o_word = '0;
        endcase
        default: o_word = '0;
      endcase
    end
  end
endmodule

// File: rtl/pkt_tx_assembler.sv
// Transmit packet assembler: captures reward response fields on reward_done
// and serializes them as a typed 16-bit word frame ending in an XOR checksum.
// Holds one active and one pending frame.
//   clk, nrst            : clock, async active-low reset
//   reward_done          : capture strobe; r* fields valid this cycle
//   rPacketType, r*      : frame type and fields
//   tx                   : valid/ready word link (master side)
//   busy                 : active frame in flight or pending slot occupied
//   drop_count           : strobes lost with both slots full (saturating)
//   bad_type_count       : strobes with undefined type (saturating)
module pkt_tx_assembler #(
  parameter int unsigned WORD_WIDTH = eer_pkg::WORD_WIDTH,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    reward_done,
  input  logic [2:0]              rPacketType,
  input  logic [WORD_WIDTH-1:0]   rSourceID,
  input  logic [WORD_WIDTH-1:0]   rDestinationID,
  input  logic [WORD_WIDTH-1:0]   rSourceHops,
  input  logic [WORD_WIDTH-1:0]   rQValue,
  input  logic [WORD_WIDTH-1:0]   rEnergyLeft,
  input  logic [WORD_WIDTH-1:0]   rChosenCH,
  input  logic [WORD_WIDTH-1:0]   rHopsFromCH,
  pkt_tx_assembler_if.master      tx,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic [CNT_WIDTH-1:0]    bad_type_count
);
  import eer_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_CSUM} state_e;

  state_e                r_state,   w_state_nx;
  tx_frame_t             r_active,  w_active_nx;
  tx_frame_t             r_pend,    w_pend_nx;
  logic                  r_pend_vld, w_pend_vld_nx;
  logic [2:0]            r_idx,     w_idx_nx;
  logic [WORD_WIDTH-1:0] r_xor,     w_xor_nx;
  logic [CNT_WIDTH-1:0]  r_drop,    w_drop_nx;
  logic [CNT_WIDTH-1:0]  r_bad,     w_bad_nx;

  tx_frame_t             w_strobe_frame;
  logic [WORD_WIDTH-1:0] w_word;
  logic                  w_last_data;
  logic                  w_fire;
  logic                  w_strobe_ok;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  assign w_strobe_frame = '{ptype:          pkt_type_e'(rPacketType),
                            source_id:      rSourceID,
                            destination_id: rDestinationID,
                            source_hops:    rSourceHops,
                            q_value:        rQValue,
                            energy_left:    rEnergyLeft,
                            chosen_ch:      rChosenCH,
                            hops_from_ch:   rHopsFromCH};

  assign w_strobe_ok = reward_done && type_is_valid(rPacketType);
  assign w_fire      = tx.tx_valid && tx.tx_ready;

  pkt_word_sel u_word_sel (
    .i_frame     (r_active),
    .i_idx       (r_idx),
    .o_word      (w_word),
    .o_last_data (w_last_data)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_active   <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_idx      <= '0;
      r_xor      <= '0;
      r_drop     <= '0;
      r_bad      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_active   <= w_active_nx;
      r_pend     <= w_pend_nx;
      r_pend_vld <= w_pend_vld_nx;
      r_idx      <= w_idx_nx;
      r_xor      <= w_xor_nx;
      r_drop     <= w_drop_nx;
      r_bad      <= w_bad_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_active_nx   = r_active;
    w_pend_nx     = r_pend;
    w_pend_vld_nx = r_pend_vld;
    w_idx_nx      = r_idx;
    w_xor_nx      = r_xor;
    w_drop_nx     = r_drop;
    w_bad_nx      = r_bad;

    if (reward_done && !type_is_valid(rPacketType)) w_bad_nx = sat_inc(r_bad);

    case (r_state)
      S_IDLE: begin
        if (w_strobe_ok) begin
          w_active_nx = w_strobe_frame;
          w_idx_nx    = '0;
          w_xor_nx    = '0;
          w_state_nx  = S_SEND;
        end
      end
      S_SEND: begin
        if (w_fire) begin
          w_xor_nx = r_xor ^ w_word;
          if (w_last_data) w_state_nx = S_CSUM;
          else             w_idx_nx   = r_idx + 3'd1;
        end
        if (w_strobe_ok) begin
          if (!r_pend_vld) begin
            w_pend_nx     = w_strobe_frame;
            w_pend_vld_nx = 1'b1;
          end else begin
            w_drop_nx = sat_inc(r_drop);
          end
        end
      end
      S_CSUM: begin
        if (w_fire) begin
          w_idx_nx = '0;
          w_xor_nx = '0;
          // Pending frame wins the freed active slot; a strobe in the same
          // cycle still sees both slots occupied and is dropped.
          if (r_pend_vld) begin
            w_active_nx   = r_pend;
            w_pend_vld_nx = 1'b0;
            w_state_nx    = S_SEND;
            if (w_strobe_ok) w_drop_nx = sat_inc(r_drop);
          end else if (w_strobe_ok) begin
            w_active_nx = w_strobe_frame;
            w_state_nx  = S_SEND;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else if (w_strobe_ok) begin
          if (!r_pend_vld) begin
            w_pend_nx     = w_strobe_frame;
            w_pend_vld_nx = 1'b1;
          end else begin
            w_drop_nx = sat_inc(r_drop);
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_state)
      S_SEND:  tx.tx_data = w_word;
      S_CSUM:  tx.tx_data = r_xor;
      default: tx.tx_data = '0;
    endcase
  end

  assign tx.tx_valid     = (r_state != S_IDLE);
  assign tx.tx_last      = (r_state == S_CSUM);
  assign busy            = (r_state != S_IDLE) || r_pend_vld;
  assign drop_count      = r_drop;
  assign bad_type_count  = r_bad;

endmodule

// File: tb/tb_pkt_tx_assembler.sv
module tb_pkt_tx_assembler;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  logic        reward_done = 1'b0;
  logic [2:0]  rPacketType = '0;
  logic [15:0] rSourceID = '0, rDestinationID = '0, rSourceHops = '0, rQValue = '0;
  logic [15:0] rEnergyLeft = '0, rChosenCH = '0, rHopsFromCH = '0;
  logic        busy;
  logic [7:0]  drop_count, bad_type_count;

  pkt_tx_assembler_if #(.WORD_WIDTH(16)) tx_if ();

  pkt_tx_assembler #(.WORD_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .reward_done    (reward_done),
    .rPacketType    (rPacketType),
    .rSourceID      (rSourceID),
    .rDestinationID (rDestinationID),
    .rSourceHops    (rSourceHops),
    .rQValue        (rQValue),
    .rEnergyLeft    (rEnergyLeft),
    .rChosenCH      (rChosenCH),
    .rHopsFromCH    (rHopsFromCH),
    .tx             (tx_if),
    .busy           (busy),
    .drop_count     (drop_count),
    .bad_type_count (bad_type_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected word stream: bit16 = last flag. nfr = frames accepted but not
  // yet fully sent (at most two: active + pending).
  logic [16:0] exp_q[$];
  int          nfr = 0;
  int          m_drop = 0;
  int          m_bad = 0;
  logic [16:0] hs_log[$];

  function automatic void push_frame(input logic [2:0] t,
                                     input logic [15:0] sid, did, sh, q, e, ch, hfc);
    logic [15:0] body[$];
    logic [15:0] hdr, cs;
    logic [3:0]  len;
    case (t)
      3'd1: body = '{sid, sh, q, e};
      3'd2: body = '{sid, e, q};
      3'd3: body = '{sid, ch, hfc};
      3'd4: body = '{sid, did, ch};
      default: body = '{sid, did, sh, e, q};
    endcase
    len = 4'(body.size() + 2);
    hdr = {t, 1'b0, len, 8'h00};
    cs  = hdr;
    exp_q.push_back({1'b0, hdr});
    foreach (body[i]) begin
      cs = cs ^ body[i];
      exp_q.push_back({1'b0, body[i]});
    end
    exp_q.push_back({1'b1, cs});
  endfunction

  initial begin : model
    int n0;
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        exp_q.delete();
        nfr = 0; m_drop = 0; m_bad = 0;
      end else begin
        n0 = nfr;
        if (exp_q.size() != 0 && tx_if.tx_ready) begin
          if (exp_q[0][16]) nfr--;
          void'(exp_q.pop_front());
        end
        if (reward_done) begin
          if (rPacketType >= 3'd1 && rPacketType <= 3'd5) begin
            if (n0 < 2) begin
              push_frame(rPacketType, rSourceID, rDestinationID, rSourceHops,
                         rQValue, rEnergyLeft, rChosenCH, rHopsFromCH);
              nfr++;
            end else if (m_drop != 255) m_drop++;
          end else if (m_bad != 255) m_bad++;
        end
      end
    end
  end

  initial begin : handshake_log
    forever begin
      @(posedge clk);
      if (nrst && tx_if.tx_valid && tx_if.tx_ready)
        hs_log.push_back({tx_if.tx_last, tx_if.tx_data});
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      check("valid", tx_if.tx_valid, 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("data", tx_if.tx_data, exp_q[0][15:0]);
        check("last", tx_if.tx_last, exp_q[0][16]);
      end else begin
        check("last_idle", tx_if.tx_last, 0);
      end
      check("busy", busy, 32'(nfr != 0));
      check("drop_count", drop_count, m_drop);
      check("bad_type_count", bad_type_count, m_bad);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_fields(input logic [2:0] t, input logic [15:0] sid, did, sh, q, e, ch, hfc);
    rPacketType = t; rSourceID = sid; rDestinationID = did; rSourceHops = sh;
    rQValue = q; rEnergyLeft = e; rChosenCH = ch; rHopsFromCH = hfc;
  endtask

  task automatic scramble();
    set_fields(3'd0, 16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h9999);
  endtask

  // Returns at the negedge after the capturing posedge
  task automatic strobe(input logic [2:0] t, input logic [15:0] sid, did, sh, q, e, ch, hfc);
    @(negedge clk);
    set_fields(t, sid, did, sh, q, e, ch, hfc);
    reward_done = 1'b1;
    @(negedge clk);
    reward_done = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("wait_idle_timeout", exp_q.size(), 0);
  endtask

  logic [15:0] hb_words [6];

  initial begin : stim
    int vcyc, d1cyc, stalls, found;
    hb_words = '{16'h2600, 16'h000C, 16'h0001, 16'h0000, 16'h8000, 16'hA60D};
    tx_if.tx_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", tx_if.tx_valid, 0);
    check("rst_data", tx_if.tx_data, 0);
    check("rst_last", tx_if.tx_last, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    check("rst_bad", bad_type_count, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // HB frame, one word per cycle
    hs_log.delete();
    strobe(3'd1, 16'h000C, 16'h1111, 16'h0001, 16'h0000, 16'h8000, 16'h2222, 16'h3333);
    check("hb_hdr_valid_n1", tx_if.tx_valid, 1);
    check("hb_hdr_data_n1", tx_if.tx_data, 16'h2600);
    wait_idle();
    check("hb_log_size", hs_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < hs_log.size()) begin
        check($sformatf("hb_word%0d", i), hs_log[i][15:0], hb_words[i]);
        check($sformatf("hb_last%0d", i), hs_log[i][16], 32'(i == 5));
      end
    end
    @(negedge clk);
    check("hb_busy_fall", busy, 0);

    // Backpressure at word 2 for 3 cycles
    strobe(3'd1, 16'h000C, 16'h1111, 16'h0001, 16'h0000, 16'h8000, 16'h2222, 16'h3333);
    vcyc = 0; d1cyc = 0; stalls = 0; found = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_if.tx_valid) vcyc++;
      if (tx_if.tx_valid && tx_if.tx_data == 16'h0001) d1cyc++;
      if (tx_if.tx_valid && tx_if.tx_data == 16'h0001 && stalls < 3) begin
        tx_if.tx_ready = 1'b0;
        stalls++;
      end else begin
        tx_if.tx_ready = 1'b1;
      end
      if (tx_if.tx_valid && tx_if.tx_last && tx_if.tx_ready) begin
        found = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    tx_if.tx_ready = 1'b1;
    check("bp_reached_end", found, 1);
    check("bp_word2_cycles", d1cyc, 4);
    check("bp_frame_cycles", vcyc, 9);
    wait_idle();

    // Queueing: three consecutive strobes
    hs_log.delete();
    @(negedge clk);
    set_fields(3'd2, 16'h0101, 16'h0000, 16'h0000, 16'h1234, 16'h00F0, 16'h0000, 16'h0000);
    reward_done = 1'b1;
    @(negedge clk);
    set_fields(3'd3, 16'h0202, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0303, 16'h0004);
    @(negedge clk);
    set_fields(3'd4, 16'h0999, 16'h0888, 16'h0000, 16'h0000, 16'h0000, 16'h0777, 16'h0000);
    @(negedge clk);
    reward_done = 1'b0;
    scramble();
    wait_idle();
    check("q_drop_count", drop_count, 1);
    check("q_log_size", hs_log.size(), 10);
    if (hs_log.size() == 10) begin
      check("q_che_hdr", hs_log[0], 17'h04500);
      check("q_che_csum", hs_log[4], 17'h156C5);
      check("q_inv_hdr", hs_log[5], 17'h06500);
      check("q_inv_csum", hs_log[9], 17'h16405);
    end

    // Invalid type
    strobe(3'd7, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007);
    repeat (2) @(negedge clk);
    check("bad_count", bad_type_count, 1);
    check("bad_busy", busy, 0);
    check("bad_valid", tx_if.tx_valid, 0);

    // Same-cycle refill on final handshake
    strobe(3'd5, 16'h0005, 16'h0006, 16'h0007, 16'h0009, 16'h0008, 16'h0000, 16'h0000);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_if.tx_valid && tx_if.tx_last) begin found = 1; break; end
      @(negedge clk);
    end
    check("refill_saw_last", found, 1);
    set_fields(3'd1, 16'h000C, 16'h1111, 16'h0001, 16'h0000, 16'h8000, 16'h2222, 16'h3333);
    reward_done = 1'b1;
    @(negedge clk);
    reward_done = 1'b0;
    scramble();
    check("refill_valid", tx_if.tx_valid, 1);
    check("refill_hdr", tx_if.tx_data, 16'h2600);
    check("refill_drop", drop_count, 1);
    wait_idle();

    // Reset during word 3
    strobe(3'd1, 16'h000C, 16'h1111, 16'h0001, 16'h0055, 16'h8000, 16'h2222, 16'h3333);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_if.tx_valid && tx_if.tx_data == 16'h0055) begin found = 1; break; end
      @(negedge clk);
    end
    check("rstmid_saw_word3", found, 1);
    #2 nrst = 1'b0;
    #1;
    check("rstmid_valid", tx_if.tx_valid, 0);
    check("rstmid_data", tx_if.tx_data, 0);
    check("rstmid_last", tx_if.tx_last, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_drop", drop_count, 0);
    check("rstmid_bad", bad_type_count, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    check("rstmid_no_resume", tx_if.tx_valid, 0);

    // DATA frame with alternating ready
    strobe(3'd5, 16'hA5A5, 16'h5A5A, 16'h0003, 16'h7777, 16'h1357, 16'h0000, 16'h0000);
    for (int c = 0; c < 16; c++) begin
      tx_if.tx_ready = c[0];
      @(negedge clk);
    end
    tx_if.tx_ready = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_tx_assembler.md
# pkt_tx_assembler

Transmit-side packet assembler sitting directly downstream of `reward`. On each `reward_done` strobe it captures the `r*` response fields and serializes them as a typed frame of 16-bit words, ending in an XOR checksum, onto a valid/ready link toward the radio/TX FIFO. It holds one active frame plus one pending frame, so `reward` never stalls. It counts dropped and invalid requests.

## Interface
- `WORD_WIDTH`, 16, width of every field and output word
- `CNT_WIDTH`, 8, width of the saturating diagnostic counters
- `clk` in 1: single clock, rising edge
- `nrst` in 1: reset, asynchronous, active-low
- `reward_done` in 1: capture strobe from `reward`; the `r*` fields are valid in this cycle
- `rPacketType` in 3: frame type
- `rSourceID`, `rDestinationID`, `rSourceHops`, `rQValue`, `rEnergyLeft`, `rChosenCH`, `rHopsFromCH` in 16 each: frame fields
- `tx_ready` in 1: sink accepts the word this cycle
- `tx_valid` out 1: `tx_data` is valid
- `tx_data` out 16: current word
- `tx_last` out 1: current word is the checksum (final word)
- `busy` out 1: active frame in flight, or pending slot occupied
- `drop_count` out CNT_WIDTH: strobes lost because both slots were full; saturates at all-ones
- `bad_type_count` out CNT_WIDTH: strobes carrying an undefined type; saturates

## Operation
- Frame layouts. Word 0 is always the header; LEN is the total word count, checksum included.
  - HB (1): header, SourceID, SourceHops, QValue, EnergyLeft, checksum. LEN = 6.
  - CHE (2): header, SourceID, EnergyLeft, QValue, checksum. LEN = 5.
  - INV (3): header, SourceID, ChosenCH, HopsFromCH, checksum. LEN = 5.
  - JOIN (4): header, SourceID, DestinationID, ChosenCH, checksum. LEN = 5.
  - DATA (5): header, SourceID, DestinationID, SourceHops, EnergyLeft, QValue, checksum. LEN = 7.
- Header word is {type[2:0], 1'b0, LEN[3:0], 8'h00}.
- Checksum is the XOR of all preceding words of the frame, header included.
- Types 0, 6 and 7 are never queued. Each such strobe increments `bad_type_count`.
- Strobe with a valid type:
  - Nothing active: the fields load into the active register.
  - Active frame, pending slot empty: the fields load into the pending slot.
  - Active frame, pending slot full: the strobe is discarded and `drop_count` increments.
  - Slot occupancy is evaluated at the start of the cycle.
- Final-word handshake (`tx_last` with `tx_valid && tx_ready`):
  - If pending is full, pending moves to active and pending clears.
  - Otherwise, a valid strobe arriving in that same cycle loads active directly; it does not increment `drop_count`.
  - Otherwise the FSM returns to IDLE.
- FSM states:
  - IDLE: `tx_valid` = 0.
  - SEND: words 0..LEN-2 of the active frame.
  - CSUM: checksum word, `tx_last` = 1.
- The word index advances only on `tx_valid && tx_ready`. The running XOR accumulates the word accepted on each handshake.
- `tx_data` and `tx_last` hold stable while `tx_valid && !tx_ready`.
- Input fields are sampled only on the strobe. Later changes on the `r*` inputs have no effect on a frame already captured.

## Timing
- Reset values: `tx_valid` = 0, `tx_data` = 0, `tx_last` = 0, `busy` = 0, both counters 0, both slots empty, word index 0, XOR accumulator 0.
- Reset asserted mid-frame aborts the frame immediately; nothing resumes after reset.
- Strobe at cycle N while IDLE: header on `tx_data` with `tx_valid` = 1 at cycle N+1.
- With `tx_ready` tied high, one word per cycle:
  - HB: header at N+1, checksum at N+6.
  - Back-to-back frames: no bubble. The next header appears in the cycle after the final-word handshake.
- `busy` rises in the cycle after a captured strobe. It falls in the cycle after the final handshake when no frame follows.
- Counter increments are visible the cycle after the strobe.

## Structure
- Shared package `eer_pkg` holds:
  - `WORD_WIDTH`
  - packet type enum `pkt_type_e` (HB = 1, CHE = 2, INV = 3, JOIN = 4, DATA = 5)
  - frame length constants per type
  - packed struct `tx_frame_t` bundling type and the seven fields
- One sub-module, `pkt_word_sel`: combinational; takes `tx_frame_t` and word index, returns the data word and a last-data-word flag.
- The FSM, both slots and the counters stay in `pkt_tx_assembler`.

## Test plan
- HB frame: strobe with type 1, SourceID 0x000C, SourceHops 1, QValue 0x0000, EnergyLeft 0x8000, `tx_ready` = 1.
  - Words: 0x2600, 0x000C, 0x0001, 0x0000, 0x8000, then checksum 0xA60D with `tx_last` = 1.
- Backpressure: same HB frame with `tx_ready` low for 3 cycles at word 2.
  - `tx_data` stays at 0x0001 with `tx_valid` = 1 for 3 cycles.
  - Total frame time is 9 cycles.
- Queueing: three valid strobes on consecutive cycles.
  - First goes to active, second to pending, third is dropped; `drop_count` = 1.
  - The two frames emit back-to-back with no idle cycle.
- Invalid type: strobe with type 7.
  - No `tx_valid`; `bad_type_count` = 1; `busy` stays 0.
- Same-cycle refill: strobe in the same cycle as the final handshake, pending empty.
  - Next header appears on the following cycle; `drop_count` unchanged.
- Reset mid-frame: `nrst` low during word 3.
  - All outputs are 0 immediately; after release, `tx_valid` stays 0 until a new strobe.
